// File: rtl/frame_minmax_scanner.sv
// Scans every frame-RAM address once and tracks the signed minimum and maximum pixel.
// Presents min and max-min to the downstream normalizer and pulses o_done when both are valid.
module frame_minmax_scanner #(
  parameter int DATAW      = 16,
  parameter int MAX_ADDR   = 63,
  parameter int RD_LATENCY = 1,
  localparam int ADDRW     = $clog2(MAX_ADDR + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_rd_valid,
  output logic [ADDRW-1:0] o_rd_addr,
  input  logic [DATAW-1:0] i_rd_data,
  output logic [DATAW-1:0] o_min,
  output logic [DATAW-1:0] o_range,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_debug_busy_req
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [ADDRW-1:0]        addr_q, addr_d;
  logic [RD_LATENCY-1:0]   vpipe_q, vpipe_d;
  logic                    first_q, first_d;
  logic signed [DATAW-1:0] min_q, min_d;
  logic signed [DATAW-1:0] max_q, max_d;
  logic [DATAW-1:0]        omin_q, omin_d;
  logic [DATAW-1:0]        orange_q, orange_d;
  logic                    done_q, done_d;
  logic                    busy_req_q, busy_req_d;
  logic signed [DATAW-1:0] smp;

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    addr_d     = addr_q;
    vpipe_d    = vpipe_q;
    first_d    = first_q;
    min_d      = min_q;
    max_d      = max_q;
    omin_d     = omin_q;
    orange_d   = orange_q;
    done_d     = 1'b0;
    busy_req_d = busy_req_q;
    smp        = $signed(i_rd_data);

    vpipe_d[0] = rd_valid_q;
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end

    if (vpipe_q[RD_LATENCY-1]) begin
      if (first_q) begin
        min_d   = smp;
        max_d   = smp;
        first_d = 1'b0;
      end else begin
        if (smp < min_q) min_d = smp;
        if (smp > max_q) max_d = smp;
      end
    end

    if (i_start && (state_q != IDLE)) busy_req_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d    = SCAN;
          addr_d     = '0;
          rd_valid_d = 1'b1;
          first_d    = 1'b1;
        end
      end
      SCAN: begin
        if (addr_q == ADDRW'(MAX_ADDR)) begin
          rd_valid_d = 1'b0;
          state_d    = DRAIN;
        end else begin
          addr_d = addr_q + ADDRW'(1);
        end
      end
      DRAIN: begin
        // Empty pipe means the final sample was folded in on the previous edge.
        if (vpipe_q == '0) begin
          omin_d = min_q;
          // max-min is never negative and below 2^DATAW, so the modular DATAW-bit
          // difference equals the exact DATAW+1-bit result.
          orange_d = DATAW'(max_q - min_q);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      rd_valid_q <= 1'b0;
      addr_q     <= '0;
      vpipe_q    <= '0;
      first_q    <= 1'b0;
      min_q      <= '0;
      max_q      <= '0;
      omin_q     <= '0;
      orange_q   <= '0;
      done_q     <= 1'b0;
      busy_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      addr_q     <= addr_d;
      vpipe_q    <= vpipe_d;
      first_q    <= first_d;
      min_q      <= min_d;
      max_q      <= max_d;
      omin_q     <= omin_d;
      orange_q   <= orange_d;
      done_q     <= done_d;
      busy_req_q <= busy_req_d;
    end
  end

  assign o_rd_valid       = rd_valid_q;
  assign o_rd_addr        = addr_q;
  assign o_min            = omin_q;
  assign o_range          = orange_q;
  assign o_done           = done_q;
  assign o_busy           = (state_q != IDLE);
  assign o_debug_busy_req = busy_req_q;

endmodule

// File: tb/tb_frame_minmax_scanner.sv
// Scoreboard bench for frame_minmax_scanner: one instance at read latency 1, one at latency 3,
// both fed from a shared behavioural frame RAM; expected results come from a direct min/max scan.
module tb_frame_minmax_scanner;

  localparam int MAXA = 63;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;

  logic        a_rd_valid, b_rd_valid;
  logic [5:0]  a_rd_addr, b_rd_addr;
  logic [15:0] a_rd_data, b_rd_data;
  logic [15:0] a_min, a_range, b_min, b_range;
  logic        a_done, a_busy, a_bsy_req, b_done, b_busy, b_bsy_req;

  frame_minmax_scanner #(.DATAW(16), .MAX_ADDR(63), .RD_LATENCY(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
    .o_rd_valid(a_rd_valid), .o_rd_addr(a_rd_addr), .i_rd_data(a_rd_data),
    .o_min(a_min), .o_range(a_range), .o_done(a_done), .o_busy(a_busy),
    .o_debug_busy_req(a_bsy_req)
  );

  frame_minmax_scanner #(.DATAW(16), .MAX_ADDR(63), .RD_LATENCY(3)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .o_rd_valid(b_rd_valid), .o_rd_addr(b_rd_addr), .i_rd_data(b_rd_data),
    .o_min(b_min), .o_range(b_range), .o_done(b_done), .o_busy(b_busy),
    .o_debug_busy_req(b_bsy_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame RAM; unqualified cycles return random garbage that the DUT must ignore.
  logic signed [15:0] mem [0:MAXA];
  logic [15:0] dla;
  logic [15:0] dlb [0:2];
  always @(posedge clk) begin
    dla     <= a_rd_valid ? mem[a_rd_addr] : 16'($urandom);
    dlb[0]  <= b_rd_valid ? mem[b_rd_addr] : 16'($urandom);
    dlb[1]  <= dlb[0];
    dlb[2]  <= dlb[1];
  end
  assign a_rd_data = dla;
  assign b_rd_data = dlb[2];

  typedef struct {
    logic [15:0] mn;
    logic [15:0] rg;
    int          cyc;
  } exp_t;

  exp_t qa[$], qb[$];
  int   rqa[$];
  exp_t ea, eb;
  int   checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  function automatic exp_t ref_scan(input int t, input int lat);
    exp_t e;
    int mn, mx;
    mn = int'(mem[0]);
    mx = int'(mem[0]);
    for (int i = 1; i <= MAXA; i++) begin
      if (int'(mem[i]) < mn) mn = int'(mem[i]);
      if (int'(mem[i]) > mx) mx = int'(mem[i]);
    end
    e.mn  = 16'(mn);
    e.rg  = 16'(mx - mn);
    e.cyc = t + MAXA + lat + 3;
    return e;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i <= MAXA; i++) begin
      case (kind)
        0:       mem[i] = 16'(i - 10);
        1:       mem[i] = 16'h0123;
        4:       mem[i] = 16'($urandom);
        5:       mem[i] = 16'(int'($urandom_range(0, 200)) - 100);
        default: mem[i] = 16'h0000;
      endcase
    end
    if (kind == 2) begin mem[5] = 16'h8000; mem[40] = 16'h7fff; end
    if (kind == 3) begin mem[0] = 16'h8000; mem[63] = 16'h7fff; end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step(1);
  endtask

  // Called at #1 after a rising edge: start is high for exactly the current cycle.
  task automatic start_scan(input bit use_b);
    if (use_b) begin
      qb.push_back(ref_scan(cyc, 3));
      start_b = 1'b1;
    end else begin
      qa.push_back(ref_scan(cyc, 1));
      rqa.push_back(cyc);
      start_a = 1'b1;
    end
    step(1);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 300) begin
      step(1);
      k++;
    end
    if (k >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, qa.size() + qb.size());
      qa.delete();
      qb.delete();
    end
    step(2);
  endtask

  // Result monitors
  logic [15:0] last_a_min = '0, last_a_rg = '0;
  always @(negedge clk) begin
    if (rst) begin
      last_a_min = '0;
      last_a_rg  = '0;
    end else if (a_done) begin
      if (qa.size() == 0) fail_now("a_spurious_done");
      else begin
        ea = qa.pop_front();
        check("a_done_cyc", cyc, ea.cyc);
        check("a_min", a_min, ea.mn);
        check("a_range", a_range, ea.rg);
        check("a_busy_in_done", a_busy, 0);
        last_a_min = ea.mn;
        last_a_rg  = ea.rg;
      end
    end else if (a_rd_valid && a_rd_addr == 6'd32) begin
      check("a_min_hold", a_min, last_a_min);
      check("a_range_hold", a_range, last_a_rg);
    end
  end

  always @(negedge clk) begin
    if (!rst && b_done) begin
      if (qb.size() == 0) fail_now("b_spurious_done");
      else begin
        eb = qb.pop_front();
        check("b_done_cyc", cyc, eb.cyc);
        check("b_min", b_min, eb.mn);
        check("b_range", b_range, eb.rg);
        check("b_busy_in_done", b_busy, 0);
      end
    end
  end

  // Read-address monitor for the latency-1 instance
  bit ra_run = 1'b0;
  int ra_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      ra_run = 1'b0;
      ra_cnt = 0;
    end else if (a_rd_valid) begin
      if (!ra_run) begin
        ra_run = 1'b1;
        ra_cnt = 0;
        if (rqa.size() == 0) fail_now("a_rd_unexpected");
        else check("a_rd_first_cyc", cyc, rqa.pop_front() + 1);
      end
      check("a_rd_addr", a_rd_addr, ra_cnt);
      ra_cnt++;
    end else if (ra_run) begin
      ra_run = 1'b0;
      check("a_rd_count", ra_cnt, MAXA + 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int t;
    fill(6);
    step(3);
    check("rst_a_rd_valid", a_rd_valid, 0);
    check("rst_a_rd_addr", a_rd_addr, 0);
    check("rst_a_min", a_min, 0);
    check("rst_a_range", a_range, 0);
    check("rst_a_done", a_done, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_bsy_req", a_bsy_req, 0);
    check("rst_b_busy", b_busy, 0);
    check("rst_b_min", b_min, 0);
    rst = 1'b0;
    step(2);

    // Ramp -10..53
    fill(0);
    start_scan(1'b0);
    check("ramp_busy_t1", a_busy, 1);
    check("ramp_rd_valid_t1", a_rd_valid, 1);
    drain("ramp");

    // Uniform, then extremes in the middle and at first/last addresses
    for (int k = 1; k <= 3; k++) begin
      fill(k);
      start_scan(1'b0);
      drain("pattern");
    end

    // Random frames
    for (int k = 0; k < 4; k++) begin
      fill(4 + (k % 2));
      start_scan(1'b0);
      drain("random");
    end

    // Start while busy: ignored, sticky flag
    fill(5);
    t = cyc;
    start_scan(1'b0);
    go_to(t + 19);
    check("bsy_req_before", a_bsy_req, 0);
    step(1);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    check("bsy_req_set", a_bsy_req, 1);
    drain("busy_req");
    check("bsy_req_held", a_bsy_req, 1);

    // Latency 3, back-to-back start in the done cycle
    fill(4);
    t = cyc;
    start_scan(1'b1);
    go_to(t + 69);
    fill(5);
    start_scan(1'b1);
    drain("b2b");

    // Reset mid-scan, then a clean scan of a new frame
    fill(4);
    t = cyc;
    start_scan(1'b0);
    go_to(t + 30);
    rst = 1'b1;
    #1;
    check("mrst_busy", a_busy, 0);
    check("mrst_rd_valid", a_rd_valid, 0);
    check("mrst_min", a_min, 0);
    check("mrst_range", a_range, 0);
    check("mrst_bsy_req", a_bsy_req, 0);
    qa.delete();
    rqa.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill(5);
    go_to(t + 40);
    start_scan(1'b0);
    drain("post_reset");

    step(20);
    check("queues_empty", qa.size() + qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
